// File: rtl/dm_frame_reader_pkg.sv
// Shared types and constants for the dot-matrix frame reader.
// Holds the state encoding, the row index width and the GO/STOP test frames.
package dm_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam int ROW_W  = 3;
    localparam int N_ROWS = 8;

    // Row 0 sits in the top byte; a 0 bit lights the pixel.
    localparam logic [63:0] FRAME_GO   = 64'hF9_F6_FE_E6_F6_F9_FF_F3;
    localparam logic [63:0] FRAME_STOP = 64'hFF_E3_DD_BE_BE_DD_E3_FF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] row_onehot(input logic [ROW_W-1:0] row);
        return 8'h01 << row;
    endfunction

    function automatic logic [7:0] row_byte(input logic [63:0] frame,
                                            input logic [ROW_W-1:0] row);
        int idx;
        idx = 8 * (N_ROWS - 1 - int'(row));
        return frame[idx +: 8];
    endfunction

endpackage

// File: rtl/dm_frame_reader.sv
// Double-buffered 8x8 dot-matrix scanner: blanks, then lights each row in turn.
// New frames are swapped in only at a frame boundary, so no partial frame is ever shown.
//
//   state    | meaning
//   ST_IDLE  | no frame received yet, display dark
//   ST_BLANK | anti-ghosting gap before a row, display dark
//   ST_SHOW  | current row lit from the active buffer
module dm_frame_reader
    import dm_frame_reader_pkg::*;
#(
    parameter int ROW_CLKS   = 12_500,
    parameter int BLANK_CLKS = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [63:0] i_Data,
    input  logic        i_Valid,
    output logic        o_Ready,
    output logic [7:0]  o_DM_Col,
    output logic [7:0]  o_DM_Row,
    output logic        o_fDone
);

    localparam int MAX_CLKS = max_int(ROW_CLKS, BLANK_CLKS);
    localparam int CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CLKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CLKS - 1);

    state_t             r_State;
    state_t             w_Next;
    logic [ROW_W-1:0]   r_Row;
    logic [CNT_W-1:0]   r_Cnt;
    logic [63:0]        r_Active;
    logic [63:0]        r_Pending;
    logic               r_PendFull;

    logic               w_Xfer;
    logic               w_BlankEnd;
    logic               w_RowEnd;
    logic               w_FrameEnd;

    assign o_Ready    = ~r_PendFull;
    assign w_Xfer     = i_Valid & ~r_PendFull;
    assign w_BlankEnd = (r_State == ST_BLANK) && (r_Cnt == BLANK_LAST);
    assign w_RowEnd   = (r_State == ST_SHOW) && (r_Cnt == ROW_LAST);
    assign w_FrameEnd = w_RowEnd && (r_Row == ROW_W'(N_ROWS - 1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_Next;
        end
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            ST_IDLE:  if (w_Xfer)     w_Next = ST_BLANK;
            ST_BLANK: if (w_BlankEnd) w_Next = ST_SHOW;
            ST_SHOW:  if (w_RowEnd)   w_Next = ST_BLANK;
            default:                  w_Next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_DM_Row = 8'h00;
        o_DM_Col = 8'hFF;
        o_fDone  = 1'b0;
        if (r_State == ST_SHOW) begin
            o_DM_Row = row_onehot(r_Row);
            o_DM_Col = row_byte(r_Active, r_Row);
            o_fDone  = w_FrameEnd;
        end
    end

    // Dwell counter restarts at every phase change, so it never exceeds MAX_CLKS-1.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Cnt <= '0;
            r_Row <= '0;
        end else begin
            if (r_State != w_Next) begin
                r_Cnt <= '0;
            end else if (r_State != ST_IDLE) begin
                r_Cnt <= r_Cnt + 1'b1;
            end
            if (w_RowEnd) begin
                r_Row <= r_Row + 1'b1;
            end
        end
    end

    // The first frame goes straight to active; later ones wait in pending for a frame end.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Active   <= '0;
            r_Pending  <= '0;
            r_PendFull <= 1'b0;
        end else begin
            if (r_State == ST_IDLE) begin
                if (w_Xfer) begin
                    r_Active <= i_Data;
                end
            end else if (w_Xfer) begin
                r_Pending  <= i_Data;
                r_PendFull <= 1'b1;
            end else if (w_FrameEnd && r_PendFull) begin
                r_Active   <= r_Pending;
                r_PendFull <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_frame_reader.sv
// Scoreboard bench for dm_frame_reader with ROW_CLKS=4, BLANK_CLKS=1.
// Stimulus queues the expected per-cycle scan output; a negedge monitor pops and compares.
module tb_dm_frame_reader;

    localparam logic [63:0] GO   = 64'hF9_F6_FE_E6_F6_F9_FF_F3;
    localparam logic [63:0] STOP = 64'hFF_E3_DD_BE_BE_DD_E3_FF;
    localparam logic [63:0] IGN  = 64'h55AA_55AA_55AA_55AA;
    localparam logic [63:0] NEWF = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [63:0] data = '0;
    logic        ready;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        fdone;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    bit          mon_en = 1'b0;

    dm_frame_reader #(.ROW_CLKS(4), .BLANK_CLKS(1)) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Data   (data),
        .i_Valid  (valid),
        .o_Ready  (ready),
        .o_DM_Col (col),
        .o_DM_Row (row),
        .o_fDone  (fdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] d);
        @(posedge clk);
        #1;
        valid = v;
        data  = d;
    endtask

    task automatic push_blank(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({8'h00, 8'hFF, 1'b0});
    endtask

    // One frame: per row one blank cycle then four lit cycles; fDone on the very last one.
    task automatic push_frame(input logic [63:0] f, input int n_entries);
        logic [7:0] b;
        logic [7:0] oh;
        int cnt;
        cnt = 0;
        for (int r = 0; r < 8; r++) begin
            if (cnt < n_entries) exp_q.push_back({8'h00, 8'hFF, 1'b0});
            cnt++;
            b  = 8'((f >> (56 - 8 * r)) & 64'hFF);
            oh = 8'h01 << r;
            for (int k = 0; k < 4; k++) begin
                if (cnt < n_entries) exp_q.push_back({oh, b, (r == 7 && k == 3)});
                cnt++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scan_underflow actual=output required=no_pending_expectation at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("scan_row", {56'h0, row}, {56'h0, mon_e[16:9]});
                check("scan_col", {56'h0, col}, {56'h0, mon_e[8:1]});
                check("scan_fdone", {63'h0, fdone}, {63'h0, mon_e[0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       v;
        logic [63:0] d;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row",   {56'h0, row},   64'h00);
        check("rst_col",   {56'h0, col},   64'hFF);
        check("rst_ready", {63'h0, ready}, 64'h1);
        check("rst_fdone", {63'h0, fdone}, 64'h0);
        rst = 1'b0;

        // Idle after reset: dark, ready.
        push_blank(20);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0);
            if (i == 0) mon_en = 1'b1;
            check("idle_ready", {63'h0, ready}, 64'h1);
        end

        // GO, STOP mid-frame, ignored frame, transfer on fDone, then reset at row 4.
        push_blank(1);
        push_frame(GO, 40);
        push_frame(STOP, 40);
        push_frame(STOP, 40);
        push_frame(NEWF, 22);
        for (int c = 0; c <= 143; c++) begin
            v = 1'b0;
            d = '0;
            if (c == 0)               begin v = 1'b1; d = GO;   end
            if (c == 15)              begin v = 1'b1; d = STOP; end
            if (c >= 17 && c <= 19)   begin v = 1'b1; d = IGN;  end
            if (c == 80)              begin v = 1'b1; d = NEWF; end
            step(v, d);
            case (c)
                0, 15, 41, 80, 121: check("ready_high", {63'h0, ready}, 64'h1);
                16, 40, 81:         check("ready_low",  {63'h0, ready}, 64'h0);
                default: ;
            endcase
        end
        check("row4_before_rst", {56'h0, row}, 64'h10);
        check("col4_before_rst", {56'h0, col}, 64'h89);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_row",   {56'h0, row},   64'h00);
        check("async_rst_col",   {56'h0, col},   64'hFF);
        check("async_rst_ready", {63'h0, ready}, 64'h1);
        check("async_rst_fdone", {63'h0, fdone}, 64'h0);
        repeat (2) begin
            step(1'b0, '0);
            check("hold_rst_row", {56'h0, row}, 64'h00);
        end
        rst = 1'b0;

        // Buffers were discarded: stay dark until a new transfer.
        push_blank(10);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0);
            if (i == 0) mon_en = 1'b1;
            check("post_rst_ready", {63'h0, ready}, 64'h1);
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
